// File: rtl/mod_add_pkg.sv
// Shared definitions for the modular add/subtract sequencer.
package mod_add_pkg;

  localparam int unsigned MOD_ADD_WIDTH = 1027;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_P1_ISSUE = 3'd1,
    S_P1_WAIT  = 3'd2,
    S_P2_ISSUE = 3'd3,
    S_P2_WAIT  = 3'd4,
    S_FIN      = 3'd5
  } state_e;

endpackage

// File: rtl/mod_add_ctrl.sv
// Modular add/subtract sequencer: drives an external multi-precision adder
// through a raw pass and an optional correction pass by the modulus.
module mod_add_ctrl
  import mod_add_pkg::*;
#(
  parameter int unsigned WIDTH = MOD_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             adder_start,
  output logic             adder_subtract,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  input  logic [WIDTH:0]   adder_result,
  input  logic             adder_done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             adder_start_q, adder_start_d;
  logic             adder_sub_q, adder_sub_d;
  logic [WIDTH-1:0] adder_a_q, adder_a_d;
  logic [WIDTH-1:0] adder_b_q, adder_b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             op_q, op_d;
  // First-pass sum/difference; bit WIDTH is the add carry or sub sign.
  logic [WIDTH:0]   s_q, s_d;

  // Next-state logic: adder operands and start pulse are set up on the
  // transition into an ISSUE state so they are registered while it is active.
  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    adder_start_d = 1'b0;
    adder_sub_d   = adder_sub_q;
    adder_a_d     = adder_a_q;
    adder_b_d     = adder_b_q;
    m_d           = m_q;
    op_d          = op_q;
    s_d           = s_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d           = in_m;
          op_d          = subtract;
          adder_a_d     = in_a;
          adder_b_d     = in_b;
          adder_sub_d   = subtract;
          adder_start_d = 1'b1;
          busy_d        = 1'b1;
          state_d       = S_P1_ISSUE;
        end
      end

      S_P1_ISSUE: state_d = S_P1_WAIT;

      S_P1_WAIT: begin
        if (adder_done) begin
          s_d = adder_result;
          // Add always trial-subtracts m; sub corrects only a negative result.
          if ((op_q == OP_ADD) || adder_result[WIDTH]) begin
            adder_a_d     = adder_result[WIDTH-1:0];
            adder_b_d     = m_q;
            adder_sub_d   = (op_q == OP_ADD);
            adder_start_d = 1'b1;
            state_d       = S_P2_ISSUE;
          end else begin
            result_d = adder_result[WIDTH-1:0];
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_FIN;
          end
        end
      end

      S_P2_ISSUE: state_d = S_P2_WAIT;

      S_P2_WAIT: begin
        if (adder_done) begin
          // Add: keep s - m when s carried out or s >= m, else keep s.
          if ((op_q == OP_SUB) || s_q[WIDTH] || !adder_result[WIDTH]) begin
            result_d = adder_result[WIDTH-1:0];
          end else begin
            result_d = s_q[WIDTH-1:0];
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FIN;
        end
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      result_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      adder_start_q <= 1'b0;
      adder_sub_q   <= 1'b0;
      adder_a_q     <= '0;
      adder_b_q     <= '0;
      m_q           <= '0;
      op_q          <= OP_ADD;
      s_q           <= '0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      adder_start_q <= adder_start_d;
      adder_sub_q   <= adder_sub_d;
      adder_a_q     <= adder_a_d;
      adder_b_q     <= adder_b_d;
      m_q           <= m_d;
      op_q          <= op_d;
      s_q           <= s_d;
    end
  end

  assign result         = result_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign adder_start    = adder_start_q;
  assign adder_subtract = adder_sub_q;
  assign adder_a        = adder_a_q;
  assign adder_b        = adder_b_q;

endmodule

// File: tb/tb_mod_add_ctrl.sv
// Bench for mod_add_ctrl with a behavioural variable-latency adder and a
// result scoreboard.
module tb_mod_add_ctrl;

  localparam int unsigned W  = 1027;
  localparam int unsigned W1 = W + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic          subtract;
  logic [W-1:0]  in_a, in_b, in_m;
  logic [W-1:0]  result;
  logic          busy, done;
  logic          adder_start, adder_subtract;
  logic [W-1:0]  adder_a, adder_b;
  logic [W:0]    adder_result;
  logic          adder_done;

  int unsigned   errors = 0;
  int unsigned   checks = 0;
  int unsigned   lat = 1;
  int unsigned   n_starts = 0;
  int unsigned   n_done = 0;
  logic [W-1:0]  exp_q[$];

  mod_add_ctrl #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .subtract       (subtract),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_m           (in_m),
    .result         (result),
    .busy           (busy),
    .done           (done),
    .adder_start    (adder_start),
    .adder_subtract (adder_subtract),
    .adder_a        (adder_a),
    .adder_b        (adder_b),
    .adder_result   (adder_result),
    .adder_done     (adder_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    logic [63:0] g, e;
    checks++;
    if (got !== exp) begin
      errors++;
      g = got[63:0];
      e = exp[63:0];
      $display("FAIL %s: got(low64)=%0h expected(low64)=%0h", tag, g, e);
    end
  endtask

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m, input logic sub);
    logic [W+1:0] t;
    if (!sub) begin
      t = {2'b00, a} + {2'b00, b};
      if (t >= {2'b00, m}) t = t - {2'b00, m};
    end else if (a >= b) begin
      t = {2'b00, a} - {2'b00, b};
    end else begin
      t = {2'b00, a} + {2'b00, m} - {2'b00, b};
    end
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < 33; i++) begin
      v = (v << 32) | {{(W-32){1'b0}}, 32'($urandom())};
    end
    return v;
  endfunction

  // Behavioural adder: takes operands in the cycle adder_start is high and
  // pulses adder_done 'lat' cycles later.
  initial begin
    logic [W-1:0] ma, mb;
    logic         ms;
    int unsigned  l;
    adder_done   = 1'b0;
    adder_result = '0;
    forever begin
      @(negedge clk);
      if (adder_start === 1'b1) begin
        ma = adder_a;
        mb = adder_b;
        ms = adder_subtract;
        l  = lat;
        @(posedge clk);
        repeat (l - 1) @(posedge clk);
        #1;
        adder_result = ms ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, ma} + {1'b0, mb});
        adder_done   = 1'b1;
        @(posedge clk);
        #1 adder_done = 1'b0;
      end
    end
  end

  // Monitor: counts adder passes and scores every done pulse.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (adder_start === 1'b1) n_starts++;
      if (done === 1'b1) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", W1'(done), '0);
        end else begin
          e = exp_q.pop_front();
          check("result", {1'b0, result}, {1'b0, e});
          check("busy_at_done", W1'(busy), '0);
        end
      end
    end
  end

  // One operation: pulse start, optionally re-pulse start at cycle dbl while
  // busy, wait (bounded) for done, then check pass count and latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                        input logic sub, input int unsigned dbl);
    int unsigned st0, cyc, passes, exp_lat;
    bit          seen;
    exp_q.push_back(ref_mod(a, b, m, sub));
    passes  = (!sub || (a < b)) ? 2 : 1;
    exp_lat = (passes == 2) ? (2 * lat + 3) : (lat + 2);
    @(posedge clk);
    #1;
    in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a = ~a; in_b = ~b; in_m = ~m; subtract = ~sub;
    st0  = n_starts;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 300 && !seen) begin
      @(negedge clk);
      cyc++;
      start = (dbl != 0 && cyc == dbl);
      if (cyc == 1) check("busy_after_start", W1'(busy), W1'(1));
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", W1'(seen), W1'(1));
    check("adder_passes", W1'(n_starts - st0), W1'(passes));
    check("latency", W1'(cyc), W1'(exp_lat));
  endtask

  initial begin
    logic [W-1:0] m, a, b, allones;
    int unsigned  nd0;

    reset = 1'b1; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", {1'b0, result}, '0);
    check("rst_busy", W1'(busy), '0);
    check("rst_done", W1'(done), '0);
    check("rst_adder_start", W1'(adder_start), '0);
    check("rst_adder_sub", W1'(adder_subtract), '0);
    check("rst_adder_a", {1'b0, adder_a}, '0);
    check("rst_adder_b", {1'b0, adder_b}, '0);
    reset = 1'b0;

    // Directed add and subtract cases, adder latency 1.
    run_op(W'(5), W'(6), W'(13), 1'b0, 0);
    run_op(W'(9), W'(7), W'(13), 1'b0, 0);
    run_op(W'(6), W'(7), W'(13), 1'b0, 0);
    allones = '1;
    a = allones - W'(1);
    run_op(a, a, allones, 1'b0, 0);
    run_op(W'(9), W'(4), W'(13), 1'b1, 0);
    run_op(W'(4), W'(9), W'(13), 1'b1, 0);
    run_op(W'(7), W'(7), W'(13), 1'b1, 0);

    // Long adder latency, start while busy.
    lat = 7;
    run_op(W'(9), W'(7), W'(13), 1'b0, 0);
    run_op(W'(4), W'(9), W'(13), 1'b1, 0);
    run_op(W'(9), W'(4), W'(13), 1'b1, 0);
    run_op(W'(12), W'(12), W'(13), 1'b0, 4);

    // Reset during P1_WAIT: everything cleared, late adder_done ignored.
    nd0 = n_done;
    @(posedge clk);
    #1;
    in_a = W'(10); in_b = W'(3); in_m = W'(13); subtract = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_result", {1'b0, result}, '0);
    check("abort_busy", W1'(busy), '0);
    check("abort_done", W1'(done), '0);
    check("abort_adder_start", W1'(adder_start), '0);
    check("abort_adder_sub", W1'(adder_subtract), '0);
    check("abort_adder_a", {1'b0, adder_a}, '0);
    check("abort_adder_b", {1'b0, adder_b}, '0);
    repeat (20) @(negedge clk);
    check("abort_no_done", W1'(n_done - nd0), '0);

    // Back-to-back random operations against the reference model.
    for (int unsigned i = 0; i < 200; i++) begin
      lat = $urandom_range(1, 4);
      if (i[1]) m = W'($urandom_range(1, 1000));
      else      m = rand_wide();
      if (m == '0) m = W'(1);
      a = rand_wide() % m;
      b = rand_wide() % m;
      if (i % 17 == 0) b = a;
      run_op(a, b, m, i[0], 0);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", W1'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_add_ctrl.md
Name: mod_add_ctrl

Overview:
- Sequencer that drives the multi-precision adder (mpadder) to compute modular addition/subtraction: r = (a + b) mod m or r = (a - b) mod m, given a, b < m.
- Issues one or two adder passes: the raw op, then a conditional correction by the modulus. It sits between the top-level Montgomery/exponentiation control and the shared mpadder instance.
- The adder is instantiated outside this block and connected through the adder_* ports.

Parameters:
- WIDTH, 1027, operand/modulus width in bits; adder result is WIDTH+1 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- subtract  in  1  0 = modular add, 1 = modular subtract; sampled with start.
- in_a  in  WIDTH  operand a, < in_m.
- in_b  in  WIDTH  operand b, < in_m.
- in_m  in  WIDTH  modulus m, nonzero.
- result  out  WIDTH  registered modular result.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- adder_start  out  1  one-cycle pulse launching an adder pass.
- adder_subtract  out  1  adder mode for the current pass.
- adder_a  out  WIDTH  adder operand A, registered.
- adder_b  out  WIDTH  adder operand B, registered.
- adder_result  in  WIDTH+1  adder output; bit WIDTH is the carry on add and the borrow/sign on subtract (two's complement of WIDTH+1 bits).
- adder_done  in  1  adder completion pulse; arbitrary latency of 1 or more cycles.

Behaviour:
- Reset (synchronous, active-high), values on the next clock edge:
  - State goes to IDLE.
  - result, adder_a, adder_b are 0.
  - busy, done, adder_start, adder_subtract are 0.
  - Operand/modulus capture registers are cleared.
- Reset mid-operation aborts the current operation. No done is generated, and any adder_done arriving afterwards is ignored.
- States: IDLE, P1_ISSUE, P1_WAIT, P2_ISSUE, P2_WAIT, FIN.
- IDLE:
  - On start, capture in_a, in_b, in_m and subtract.
  - Next state is P1_ISSUE. busy rises the following cycle.
- P1_ISSUE:
  - Drive adder_a = a, adder_b = b, adder_subtract = op, and pulse adder_start for exactly one cycle.
  - Next state is P1_WAIT.
- P1_WAIT:
  - Hold the adder operands stable. On adder_done, latch adder_result into an internal WIDTH+1-bit register s.
  - Add op: always go to P2_ISSUE with operands (s[WIDTH-1:0] + s[WIDTH] carry folded as full WIDTH+1 value, m) and adder_subtract = 1. The implementation passes s[WIDTH-1:0] and records s[WIDTH] as carry c.
  - Sub op: if s[WIDTH] = 1 (negative), go to P2_ISSUE with operands (s[WIDTH-1:0], m) and adder_subtract = 0. Otherwise result <= s[WIDTH-1:0] and go to FIN.
- P2_ISSUE: one-cycle adder_start pulse, then P2_WAIT.
- P2_WAIT, on adder_done with pass result t:
  - Add op: if c = 1 or t[WIDTH] = 0 (s >= m), result <= t[WIDTH-1:0]; else result <= s[WIDTH-1:0].
  - Sub op: result <= t[WIDTH-1:0], with the carry discarded.
  - Next state is FIN.
- FIN: done = 1 for one cycle, busy drops in the same cycle, next state is IDLE. A start in the cycle after FIN is accepted.
- Latency: add = 2 adder passes + 3 cycles overhead; sub with no correction = 1 pass + 2 cycles.
- Boundary conditions:
  - start while busy is ignored.
  - adder_done outside a WAIT state is ignored.
  - adder_done in the same cycle as adder_start is not possible; it is ignored if seen in an ISSUE state.
  - a + b == m gives result 0; a == b on subtract gives result 0.
  - Input operands may change freely after the start cycle.
  - No timeout: the block waits for adder_done indefinitely.

Decomposition:
- Shared package mod_add_pkg holds:
  - The state enum (3-bit encoding).
  - OP_ADD/OP_SUB constants.
  - The WIDTH default 1027.
- No sub-module: one FSM plus capture registers. The mpadder stays external so the bench can drive a behavioural adder model with variable latency.

Test Plan:
1. Add, no wrap: m=13, a=5, b=6 -> two adder passes; result=11, done 1 cycle, busy low afterwards.
2. Add, wrap and exact: m=13, a=9, b=7 -> result=3. Then a=6, b=7 -> result=0.
3. Add, carry out: m=2^1027-1, a=b=2^1027-2 -> first pass carry=1; result=2^1027-3.
4. Sub: m=13, a=9, b=4 -> single adder pass (count adder_start=1), result=5. Then a=4, b=9 -> two passes, result=8. Then a=b=7 -> result=0.
5. Robustness: model adder latency 1 and 7 cycles; start pulsed while busy -> ignored, single done; reset asserted during P1_WAIT -> all outputs 0 next cycle, late adder_done ignored, no done.
6. Back-to-back: start on the cycle after done (add then sub, random a, b < random m, 200 iterations) -> every result matches the reference model (a ± b) mod m.
